alu_iter_unit: RTL and testbench
================================

// Module: alu_iter_unit
// PURPOSE
//  Parametrised execute-stage ALU, successor to the single-cycle ALU. Keeps the
//  existing 4-bit exe_cmd op set; adds iterative MUL (shift-add) and UDIV (restoring).
//  Operands are taken and results returned through valid/ready handshakes.
//  Results and status are registered. Sits between ID/EX operand latch and EX/MEM.
// PARAMETERS
//  WIDTH   32   operand/result width (>=4)
//  CNT_W   $clog2(WIDTH+1)   iteration counter width (derived, do not override)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-high
//  flush        in   1      synchronous abort of any in-flight op
//  in_valid     in   1      operands/command valid
//  in_ready     out  1      unit can accept (state IDLE)
//  in1          in   WIDTH  operand A (Rn)
//  in2          in   WIDTH  operand B (shifter operand / divisor)
//  carry_in     in   1      C flag from status register
//  exe_cmd      in   4      op select (see BEHAVIOUR)
//  out_valid    out  1      result/status valid (state DONE)
//  out_ready    in   1      consumer takes result
//  result       out  WIDTH  result / MUL low half / UDIV quotient
//  rem_out      out  WIDTH  UDIV remainder; 0 for all other ops
//  status_bits  out  4      {N,Z,C,V}
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, result=0, rem_out=0, status_bits=0.
//  FSM: IDLE -> (accept, 1-cycle op) DONE; IDLE -> (accept, MUL/UDIV) BUSY;
//   BUSY -> (counter==1) DONE; DONE -> (out_ready) IDLE. flush: any state -> IDLE
//   next edge, out_valid drops, no result delivered; flush wins over accept/out_ready.
//  Accept = in_valid & in_ready at rising edge; in_ready==1 only in IDLE (comb).
//  Ops (exe_cmd): 0001 MOV=in2; 1001 MVN=~in2; 0010 ADD=in1+in2; 0011 ADC=in1+in2+cin;
//   0100 SUB=in1-in2; 0101 SBC=in1-in2-~cin; 0110 AND; 0111 ORR; 1000 EOR;
//   1010 MUL=low WIDTH bits of in1*in2; 1011 UDIV=in1/in2; others: result 0.
//  Arithmetic done at WIDTH+1 bits; C = bit WIDTH of that sum/difference (for
//   SUB/SBC C=1 means borrow). Logic/MOV/MVN/MUL/UDIV/undefined: C=0.
//  V: ADD/ADC signed overflow (same-sign operands, result sign differs);
//   SUB/SBC: operand signs differ and result sign != in1 sign; UDIV by zero: V=1;
//   else 0. N=result[WIDTH-1]; Z=(result==0). Flags latched with result.
//  Latency: 1-cycle ops -> out_valid on the cycle after accept. MUL/UDIV: operands
//   latched at accept, counter=WIDTH, one bit per BUSY cycle; out_valid first high
//   WIDTH+1 cycles after the accept edge.
//  MUL: LSB-first shift-add of in2 multiplicand; only low WIDTH bits kept.
//  UDIV: restoring, MSB first; in2==0 -> quotient all ones, rem_out=in1, V=1,
//   still takes WIDTH BUSY cycles (fixed latency).
//  DONE: result/rem_out/status held stable while out_valid & ~out_ready.
//  Throughput: max one op per 2 cycles (no accept in DONE). Inputs ignored while
//   BUSY/DONE. Async rst mid-BUSY: immediate return to reset values.
// TESTING
//  ADD 0x7FFFFFFF+1, valid 1 cycle -> next cycle out_valid, result 0x80000000, NZCV=1001.
//  SUB 3-5 -> result 0xFFFFFFFE, NZCV=1010; SBC 5-3 cin=0 -> result 1, NZCV=0000.
//  MUL 0x10000*0x10001 -> out_valid after 33 cycles, result 0x00010000, C=0,V=0.
//  UDIV 100/7 -> result 14, rem_out 2; UDIV 9/0 -> result 0xFFFFFFFF, rem 9, V=1.
//  Hold out_ready=0 5 cycles after DONE -> outputs stable, in_ready=0; then accept next.
//  flush at BUSY cycle 10, and rst at BUSY cycle 5 -> IDLE, out_valid never set,
//   in_ready=1 next cycle (flush) / immediately (rst); following ADD returns correctly.
//  Repeat ADD/MUL/UDIV sanity at WIDTH=8: 0xFF+1 -> 0x00, C=1, Z=1; MUL done in 9 cycles.

Source files
------------

// File: rtl/alu_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter_unit
// Brief    : Execute-stage ALU with valid/ready handshakes; single-cycle ops
//            plus iterative shift-add MUL and restoring UDIV.
// Revision : 1.0 - initial release
// ============================================================================
module alu_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carry_in,
    input  logic [3:0]       exe_cmd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem_out,
    output logic [3:0]       status_bits
);

    localparam logic [3:0] c_OP_MOV  = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_ADC  = 4'b0011;
    localparam logic [3:0] c_OP_SUB  = 4'b0100;
    localparam logic [3:0] c_OP_SBC  = 4'b0101;
    localparam logic [3:0] c_OP_AND  = 4'b0110;
    localparam logic [3:0] c_OP_ORR  = 4'b0111;
    localparam logic [3:0] c_OP_EOR  = 4'b1000;
    localparam logic [3:0] c_OP_MVN  = 4'b1001;
    localparam logic [3:0] c_OP_MUL  = 4'b1010;
    localparam logic [3:0] c_OP_UDIV = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_rem;
    logic [3:0]       r_status;

    logic             w_accept;
    logic             w_iter_op;
    logic [WIDTH:0]   w_ext;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_opa_nxt;
    logic [WIDTH-1:0] w_opb_nxt;
    logic [WIDTH-1:0] w_fin_res;
    logic [WIDTH-1:0] w_fin_rem;

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign result      = r_result;
    assign rem_out     = r_rem;
    assign status_bits = r_status;

    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_iter_op = (exe_cmd == c_OP_MUL) || (exe_cmd == c_OP_UDIV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_iter_op ? S_BUSY : S_DONE;
            S_BUSY:  if (r_cnt == CNT_W'(1)) w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Single-cycle ops: arithmetic carried one bit wider so the top bit is C.
    always_comb begin
        w_ext     = '0;
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (exe_cmd)
            c_OP_MOV: w_alu_res = in2;
            c_OP_MVN: w_alu_res = ~in2;
            c_OP_AND: w_alu_res = in1 & in2;
            c_OP_ORR: w_alu_res = in1 | in2;
            c_OP_EOR: w_alu_res = in1 ^ in2;
            c_OP_ADD, c_OP_ADC: begin
                w_ext     = {1'b0, in1} + {1'b0, in2}
                          + {{WIDTH{1'b0}}, (exe_cmd == c_OP_ADC) & carry_in};
                w_alu_res = w_ext[WIDTH-1:0];
                w_alu_c   = w_ext[WIDTH];
                w_alu_v   = (in1[WIDTH-1] == in2[WIDTH-1])
                          && (w_alu_res[WIDTH-1] != in1[WIDTH-1]);
            end
            c_OP_SUB, c_OP_SBC: begin
                w_ext     = {1'b0, in1} - {1'b0, in2}
                          - {{WIDTH{1'b0}}, (exe_cmd == c_OP_SBC) & ~carry_in};
                w_alu_res = w_ext[WIDTH-1:0];
                w_alu_c   = w_ext[WIDTH];
                w_alu_v   = (in1[WIDTH-1] != in2[WIDTH-1])
                          && (w_alu_res[WIDTH-1] != in1[WIDTH-1]);
            end
            default: w_alu_res = '0;
        endcase
    end

    // One iteration step: r_acc is the product or partial remainder, r_opa the
    // multiplier or the dividend/quotient shift register, r_opb the other operand.
    always_comb begin
        w_div_shift = {r_acc, r_opa[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opb});
        if (r_is_div) begin
            w_acc_nxt = w_div_ge ? (w_div_shift[WIDTH-1:0] - r_opb) : w_div_shift[WIDTH-1:0];
            w_opa_nxt = {r_opa[WIDTH-2:0], w_div_ge};
            w_opb_nxt = r_opb;
        end else begin
            w_acc_nxt = r_opa[0] ? (r_acc + r_opb) : r_acc;
            w_opa_nxt = r_opa >> 1;
            w_opb_nxt = r_opb << 1;
        end
        w_fin_res = r_is_div ? w_opa_nxt : w_acc_nxt;
        w_fin_rem = r_is_div ? w_acc_nxt : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_rem    <= '0;
            r_status <= '0;
        end else if (w_accept) begin
            r_cnt    <= CNT_W'(WIDTH);
            r_is_div <= (exe_cmd == c_OP_UDIV);
            r_acc    <= '0;
            r_opa    <= in1;
            r_opb    <= in2;
            if (!w_iter_op) begin
                r_result <= w_alu_res;
                r_rem    <= '0;
                r_status <= {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v};
            end
        end else if ((r_state == S_BUSY) && !flush) begin
            r_cnt <= r_cnt - CNT_W'(1);
            r_acc <= w_acc_nxt;
            r_opa <= w_opa_nxt;
            r_opb <= w_opb_nxt;
            if (r_cnt == CNT_W'(1)) begin
                r_result <= w_fin_res;
                r_rem    <= w_fin_rem;
                r_status <= {w_fin_res[WIDTH-1], (w_fin_res == '0), 1'b0,
                             r_is_div & (r_opb == '0)};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_iter_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_iter_unit
// Brief    : Self-checking bench for alu_iter_unit (WIDTH=32 and WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_iter_unit;

    localparam logic [3:0] c_MOV  = 4'b0001;
    localparam logic [3:0] c_ADD  = 4'b0010;
    localparam logic [3:0] c_ADC  = 4'b0011;
    localparam logic [3:0] c_SUB  = 4'b0100;
    localparam logic [3:0] c_SBC  = 4'b0101;
    localparam logic [3:0] c_AND  = 4'b0110;
    localparam logic [3:0] c_ORR  = 4'b0111;
    localparam logic [3:0] c_EOR  = 4'b1000;
    localparam logic [3:0] c_MVN  = 4'b1001;
    localparam logic [3:0] c_MUL  = 4'b1010;
    localparam logic [3:0] c_UDIV = 4'b1011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        carry_in = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  exe_cmd = 4'd0;
    logic        in_valid = 1'b0;
    logic        in_valid8 = 1'b0;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic [7:0]  in1_8 = '0;
    logic [7:0]  in2_8 = '0;
    logic        in_ready, out_valid, in_ready8, out_valid8;
    logic [31:0] result, rem_out;
    logic [7:0]  result8, rem8;
    logic [3:0]  status_bits, status8;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          use8 = 1'b0;
    logic [31:0] m_res, m_rem;
    logic [3:0]  m_st;
    logic        m_ov, m_ir;
    logic [31:0] last_res, last_rem;
    logic [3:0]  last_st;
    int          last_lat;

    alu_iter_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .carry_in(carry_in), .exe_cmd(exe_cmd),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .rem_out(rem_out), .status_bits(status_bits)
    );

    alu_iter_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid8), .in_ready(in_ready8),
        .in1(in1_8), .in2(in2_8), .carry_in(carry_in), .exe_cmd(exe_cmd),
        .out_valid(out_valid8), .out_ready(out_ready), .result(result8),
        .rem_out(rem8), .status_bits(status8)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_res = use8 ? {24'd0, result8} : result;
        m_rem = use8 ? {24'd0, rem8} : rem_out;
        m_st  = use8 ? status8 : status_bits;
        m_ov  = use8 ? out_valid8 : out_valid;
        m_ir  = use8 ? in_ready8 : in_ready;
    end

    // Reference: plain integer arithmetic on unsigned/signed interpretations.
    function automatic void model(input int w, input logic [3:0] cmd, input longint a,
                                  input longint b, input logic cin, output longint res,
                                  output longint rem, output logic [3:0] st, output int lat);
        longint m, h, sa, sb, s, ci, bo, t;
        logic   c, v;
        m   = (longint'(1) << w) - 1;
        h   = longint'(1) << (w - 1);
        sa  = (a >= h) ? a - m - 1 : a;
        sb  = (b >= h) ? b - m - 1 : b;
        ci  = cin ? 1 : 0;
        res = 0; rem = 0; c = 1'b0; v = 1'b0; lat = 1;
        case (cmd)
            c_MOV: res = b;
            c_MVN: res = m - b;
            c_AND: res = a & b;
            c_ORR: res = a | b;
            c_EOR: res = a ^ b;
            c_ADD, c_ADC: begin
                t   = a + b + ((cmd == c_ADC) ? ci : 0);
                res = t & m;
                c   = (t > m);
                s   = sa + sb + ((cmd == c_ADC) ? ci : 0);
                v   = (s >= h) || (s < -h);
            end
            c_SUB, c_SBC: begin
                bo  = (cmd == c_SBC) ? 1 - ci : 0;
                res = (a - b - bo) & m;
                c   = (a < b + bo);
                s   = sa - sb - bo;
                v   = (s >= h) || (s < -h);
            end
            c_MUL: begin
                res = (a * b) & m;
                lat = w + 1;
            end
            c_UDIV: begin
                if (b == 0) begin
                    res = m; rem = a; v = 1'b1;
                end else begin
                    res = a / b; rem = a % b;
                end
                lat = w + 1;
            end
            default: res = 0;
        endcase
        st = {(res & h) != 0, res == 0, c, v};
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input bit sel8, input logic [3:0] cmd, input logic [31:0] a,
                          input logic [31:0] b, input logic cin, input int hold);
        longint      e_res, e_rem;
        logic [3:0]  e_st;
        int          e_lat, lat;
        logic [31:0] am, bm;
        use8 = sel8;
        am = sel8 ? (a & 32'hFF) : a;
        bm = sel8 ? (b & 32'hFF) : b;
        model(sel8 ? 8 : 32, cmd, longint'(am), longint'(bm), cin, e_res, e_rem, e_st, e_lat);
        @(negedge clk);
        n_checks++;
        if (m_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_idle cmd=%b got=%b want=1", cmd, m_ir);
        end
        exe_cmd  = cmd;
        carry_in = cin;
        if (sel8) begin
            in_valid8 = 1'b1; in1_8 = am[7:0]; in2_8 = bm[7:0];
        end else begin
            in_valid = 1'b1; in1 = a; in2 = b;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_valid8 = 1'b0;
        lat = 1;
        while (m_ov !== 1'b1 && lat < 80) begin
            exe_cmd = 4'($urandom); carry_in = 1'($urandom);
            in1 = $urandom; in2 = $urandom; in1_8 = 8'($urandom); in2_8 = 8'($urandom);
            if (sel8) in_valid8 = 1'($urandom); else in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (m_ov !== 1'b1) begin
            n_fail++;
            $display("FAIL out_valid_timeout cmd=%b got=%b want=1", cmd, m_ov);
        end
        n_checks++;
        if (lat != e_lat) begin
            n_fail++;
            $display("FAIL latency cmd=%b got=%0d want=%0d", cmd, lat, e_lat);
        end
        n_checks++;
        if (m_res !== 32'(e_res)) begin
            n_fail++;
            $display("FAIL result cmd=%b a=%h b=%h cin=%b got=%h want=%h", cmd, am, bm, cin, m_res, 32'(e_res));
        end
        n_checks++;
        if (m_rem !== 32'(e_rem)) begin
            n_fail++;
            $display("FAIL rem_out cmd=%b a=%h b=%h got=%h want=%h", cmd, am, bm, m_rem, 32'(e_rem));
        end
        n_checks++;
        if (m_st !== e_st) begin
            n_fail++;
            $display("FAIL status cmd=%b a=%h b=%h cin=%b got=%b want=%b", cmd, am, bm, cin, m_st, e_st);
        end
        last_res = m_res; last_rem = m_rem; last_st = m_st; last_lat = lat;
        for (int i = 0; i < hold; i++) begin
            if (sel8) in_valid8 = 1'b1; else in_valid = 1'b1;
            in1 = $urandom; in2 = $urandom; in1_8 = 8'($urandom); exe_cmd = 4'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (m_ov !== 1'b1 || m_ir !== 1'b0 || m_res !== 32'(e_res)
                || m_rem !== 32'(e_rem) || m_st !== e_st) begin
                n_fail++;
                $display("FAIL hold_stable cyc=%0d got ov=%b ir=%b res=%h st=%b want ov=1 ir=0 res=%h st=%b",
                         i, m_ov, m_ir, m_res, m_st, 32'(e_res), e_st);
            end
        end
        in_valid = 1'b0; in_valid8 = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (m_ov !== 1'b0 || m_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL release got ov=%b ir=%b want ov=0 ir=1", m_ov, m_ir);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #2;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0
            || rem_out !== 32'd0 || status_bits !== 4'd0) begin
            n_fail++;
            $display("FAIL reset32 got ir=%b ov=%b res=%h rem=%h st=%b want 1 0 0 0 0",
                     in_ready, out_valid, result, rem_out, status_bits);
        end
        n_checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || result8 !== 8'd0
            || rem8 !== 8'd0 || status8 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset8 got ir=%b ov=%b res=%h rem=%h st=%b want 1 0 0 0 0",
                     in_ready8, out_valid8, result8, rem8, status8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_arith();
        run_op(0, c_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0, 0);
        n_checks++;
        if (last_res !== 32'h8000_0000 || last_st !== 4'b1001 || last_lat != 1) begin
            n_fail++;
            $display("FAIL add_ovf got res=%h st=%b lat=%0d want 80000000 1001 1", last_res, last_st, last_lat);
        end
        run_op(0, c_SUB, 32'd3, 32'd5, 1'b0, 0);
        n_checks++;
        if (last_res !== 32'hFFFF_FFFE || last_st !== 4'b1010) begin
            n_fail++;
            $display("FAIL sub_borrow got res=%h st=%b want fffffffe 1010", last_res, last_st);
        end
        run_op(0, c_SBC, 32'd5, 32'd3, 1'b0, 0);
        n_checks++;
        if (last_res !== 32'd1 || last_st !== 4'b0000) begin
            n_fail++;
            $display("FAIL sbc got res=%h st=%b want 00000001 0000", last_res, last_st);
        end
        run_op(0, c_ADC, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        run_op(0, c_MVN, 32'h0, 32'h0, 1'b1, 0);
        run_op(0, c_EOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 0);
        run_op(0, 4'b1111, 32'h1234, 32'h5678, 1'b1, 0);
    endtask

    task automatic test_mul();
        run_op(0, c_MUL, 32'h0001_0000, 32'h0001_0001, 1'b0, 0);
        n_checks++;
        if (last_res !== 32'h0001_0000 || last_st[1:0] !== 2'b00 || last_lat != 33) begin
            n_fail++;
            $display("FAIL mul_spec got res=%h cv=%b lat=%0d want 00010000 00 33", last_res, last_st[1:0], last_lat);
        end
        run_op(0, c_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    endtask

    task automatic test_udiv();
        run_op(0, c_UDIV, 32'd100, 32'd7, 1'b0, 0);
        n_checks++;
        if (last_res !== 32'd14 || last_rem !== 32'd2) begin
            n_fail++;
            $display("FAIL udiv_100_7 got q=%h r=%h want 0000000e 00000002", last_res, last_rem);
        end
        run_op(0, c_UDIV, 32'd9, 32'd0, 1'b0, 0);
        n_checks++;
        if (last_res !== 32'hFFFF_FFFF || last_rem !== 32'd9 || last_st[0] !== 1'b1 || last_lat != 33) begin
            n_fail++;
            $display("FAIL udiv_by_zero got q=%h r=%h v=%b lat=%0d want ffffffff 00000009 1 33",
                     last_res, last_rem, last_st[0], last_lat);
        end
    endtask

    task automatic test_hold();
        run_op(0, c_UDIV, 32'd1000, 32'd3, 1'b0, 5);
        run_op(0, c_ORR, 32'hF0F0_0000, 32'h0000_0F0F, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_op(0, c_ADD, 32'd10, 32'd20, 1'b0, 0);
        run_op(0, c_MUL, 32'd123, 32'd456, 1'b0, 0);
        run_op(0, c_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 0);
        run_op(0, c_UDIV, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
        run_op(0, c_MOV, 32'd0, 32'hDEAD_BEEF, 1'b0, 0);
    endtask

    task automatic test_flush();
        bit seen;
        use8 = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; exe_cmd = c_ADD; in1 = 32'd1; in2 = 32'd2; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_vs_accept got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b1; exe_cmd = c_MUL; in1 = 32'd77; in2 = 32'd99;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_before_flush got ir=%b ov=%b want 0 0", in_ready, out_valid);
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy got ir=%b ov=%b want 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_no_result got out_valid_seen=1 want 0");
        end
        run_op(0, c_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1; exe_cmd = c_SUB; in1 = 32'd9; in2 = 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_rst_busy();
        use8 = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; exe_cmd = c_UDIV; in1 = 32'd5000; in2 = 32'd13;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0
            || rem_out !== 32'd0 || status_bits !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_busy got ir=%b ov=%b res=%h rem=%h st=%b want 1 0 0 0 0",
                     in_ready, out_valid, result, rem_out, status_bits);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(0, c_ADD, 32'd40, 32'd2, 1'b0, 0);
        n_checks++;
        if (last_res !== 32'd42) begin
            n_fail++;
            $display("FAIL add_after_rst got res=%h want 0000002a", last_res);
        end
    endtask

    task automatic test_width8();
        run_op(1, c_ADD, 32'hFF, 32'h1, 1'b0, 0);
        n_checks++;
        if (last_res !== 32'd0 || last_st[2] !== 1'b1 || last_st[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL w8_add got res=%h z=%b c=%b want 00 1 1", last_res, last_st[2], last_st[1]);
        end
        run_op(1, c_MUL, 32'd13, 32'd11, 1'b0, 0);
        n_checks++;
        if (last_lat != 9 || last_res !== 32'h8F) begin
            n_fail++;
            $display("FAIL w8_mul got lat=%0d res=%h want 9 0000008f", last_lat, last_res);
        end
        run_op(1, c_UDIV, 32'd200, 32'd7, 1'b0, 2);
        run_op(1, c_UDIV, 32'd37, 32'd0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_op(0, 4'($urandom), rand_opnd(), rand_opnd(), 1'($urandom), $urandom_range(0, 1));
        end
        for (int i = 0; i < 25; i++) begin
            run_op(1, 4'($urandom), rand_opnd(), rand_opnd(), 1'($urandom), 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arith();
        test_mul();
        test_udiv();
        test_hold();
        test_back_to_back();
        test_flush();
        test_rst_busy();
        test_width8();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
